buffer_f6_bias_tx: RTL and testbench

Transmitter side of the F6 bias stream. On a start pulse it reads NUM bias words from a synchronous parameter memory and drives them out as the f6_bias_data / f6_bias_en stream consumed by the F6 bias buffer. The bias buffer counts enable pulses modulo NUM, so this block must emit exactly NUM enable pulses per start, in address order. It sits between the parameter ROM/BRAM and the F6 bias buffer, and is sequenced by the layer controller.

---
 rtl/buffer_f6_bias_tx.sv | 145 ++++++++++++++
 tb/tb_buffer_f6_bias_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_f6_bias_tx.sv
// ---------------------------------------------------------------------------
// buffer_f6_bias_tx
//
// Transmitter for the F6 bias stream. A start pulse makes the block read NUM
// consecutive bias words (ADDR_BASE .. ADDR_BASE+NUM-1) from a synchronous
// parameter memory. The words leave in address order on f6_bias_data, each
// one flagged by one f6_bias_en pulse. A stall input can pause the reads.
//
// Ports:
//   i_sclk        clock
//   i_rstn        asynchronous active-low reset
//   i_start       single-cycle start request (ignored while busy)
//   i_hold        downstream stall; stops new reads while high
//   o_rd_en       memory read enable
//   o_rd_addr     memory read address
//   i_rd_data     memory read data, valid the cycle after o_rd_en
//   f6_bias_data  bias word to the F6 bias buffer
//   f6_bias_en    bias word valid, one pulse per word
//   o_busy        transfer in progress
//   o_done        single-cycle pulse after the last word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module buffer_f6_bias_tx #(
    parameter int WD        = 8,
    parameter int NUM       = 84,
    parameter int AW        = 7,
    parameter int ADDR_BASE = 0
) (
    input  logic          i_sclk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic          i_hold,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [WD-1:0] i_rd_data,
    output logic [WD-1:0] f6_bias_data,
    output logic          f6_bias_en,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = $clog2(NUM + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM - 1);
    localparam logic [AW-1:0] BASE_A   = AW'(ADDR_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q,     state_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic           rd_en_q,     rd_en_d;
    logic [AW-1:0]  rd_addr_q,   rd_addr_d;
    logic           rd_en_p1_q,  rd_en_p1_d;
    logic           bias_en_q,   bias_en_d;
    logic [WD-1:0]  bias_data_q, bias_data_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;

        case (state_q)
            // The first read is issued straight from IDLE so that o_rd_en
            // rises in the cycle right after the start is sampled.
            S_IDLE, S_ISSUE: begin
                if (state_q == S_ISSUE || i_start) begin
                    state_d = S_ISSUE;
                    if (!i_hold) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = BASE_A + AW'(cnt_q);
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            // Once both pipeline stages are empty, the last word is on the
            // output in this cycle; o_done follows in the next one.
            S_DRAIN: begin
                if (!rd_en_q && !rd_en_p1_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // Read data arrives one cycle after o_rd_en; capture it then and
        // flag it valid one cycle later. The word holds while no new one arrives.
        rd_en_p1_d  = rd_en_q;
        bias_en_d   = rd_en_p1_q;
        bias_data_d = rd_en_p1_q ? i_rd_data : bias_data_q;
    end

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= BASE_A;
            rd_en_p1_q  <= 1'b0;
            bias_en_q   <= 1'b0;
            bias_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_p1_q  <= rd_en_p1_d;
            bias_en_q   <= bias_en_d;
            bias_data_q <= bias_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_rd_addr    = rd_addr_q;
    assign f6_bias_en   = bias_en_q;
    assign f6_bias_data = bias_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_buffer_f6_bias_tx.sv
// ---------------------------------------------------------------------------
// Testbench for buffer_f6_bias_tx. A default instance (NUM=84, base 0) runs
// full transfers with a range of stall patterns. A second instance
// (NUM=1, base 5) covers the single-word case. Expected per-cycle
// behaviour comes from the issue rule: one read per un-stalled cycle,
// enable two cycles later, done one cycle after the last enable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_buffer_f6_bias_tx;

    localparam int NUM  = 84;
    localparam int BASE = 0;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, hold;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] bias_data;
    logic       bias_en, busy, done;

    logic       start1;
    logic       rd_en1;
    logic [6:0] rd_addr1;
    logic [7:0] rd_data1;
    logic [7:0] bias_data1;
    logic       bias_en1, busy1, done1;

    logic [7:0] mem  [0:127];
    logic [7:0] mem1 [0:127];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_data;

    always #5 clk = ~clk;

    buffer_f6_bias_tx #(.WD(8), .NUM(NUM), .AW(7), .ADDR_BASE(BASE)) dut (
        .i_sclk(clk), .i_rstn(rstn), .i_start(start), .i_hold(hold),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .f6_bias_data(bias_data), .f6_bias_en(bias_en),
        .o_busy(busy), .o_done(done)
    );

    buffer_f6_bias_tx #(.WD(8), .NUM(1), .AW(7), .ADDR_BASE(5)) dut1 (
        .i_sclk(clk), .i_rstn(rstn), .i_start(start1), .i_hold(1'b0),
        .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
        .f6_bias_data(bias_data1), .f6_bias_en(bias_en1),
        .o_busy(busy1), .o_done(done1)
    );

    // Synchronous memories: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en1) rd_data1 <= mem1[rd_addr1];
    end

    // One full transfer on the default instance. mode 0: no stall,
    // 1: stall in cycles lo..hi, 2: random stalls. restart re-pulses
    // i_start in cycle 20 and in the o_done cycle.
    task automatic run_transfer(input string name, input int mode, input int lo,
                                input int hi, input bit restart);
        bit         h  [MAXC];
        bit         er [MAXC];
        logic [6:0] ea [MAXC];
        bit         ee [MAXC];
        logic [7:0] ed [MAXC];
        int         idx, c, last_en, done_c, pulses;
        logic [7:0] d;

        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                1:       h[i] = (i >= lo && i <= hi);
                2:       h[i] = (i < 300) && ($urandom_range(0, 3) == 0);
                default: h[i] = 1'b0;
            endcase
            er[i] = 1'b0; ea[i] = '0; ee[i] = 1'b0; ed[i] = '0;
        end

        idx = 0; c = 0; last_en = 0;
        while (idx < NUM) begin
            if (!h[c]) begin
                er[c+1] = 1'b1;
                ea[c+1] = 7'(BASE + idx);
                ee[c+3] = 1'b1;
                ed[c+3] = mem[BASE + idx];
                last_en = c + 3;
                idx++;
            end
            c++;
        end
        done_c = last_en + 1;
        d = last_data;
        for (int k = 1; k <= done_c; k++) begin
            if (ee[k]) d = ed[k];
            ed[k] = d;
        end

        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s idle_busy cyc 0 got %0b exp 0", name, busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL %s idle_done cyc 0 got %0b exp 0", name, done);
        end
        start = 1'b1;
        hold  = h[0];

        pulses = 0;
        for (int k = 1; k <= done_c; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rd_en !== er[k]) begin
                errors++; $display("FAIL %s rd_en cyc %0d got %0b exp %0b", name, k, rd_en, er[k]);
            end
            if (er[k]) begin
                checks++;
                if (rd_addr !== ea[k]) begin
                    errors++; $display("FAIL %s rd_addr cyc %0d got %0d exp %0d", name, k, rd_addr, ea[k]);
                end
            end
            checks++;
            if (bias_en !== ee[k]) begin
                errors++; $display("FAIL %s bias_en cyc %0d got %0b exp %0b", name, k, bias_en, ee[k]);
            end
            checks++;
            if (bias_data !== ed[k]) begin
                errors++; $display("FAIL %s bias_data cyc %0d got %0h exp %0h", name, k, bias_data, ed[k]);
            end
            checks++;
            if (done !== (k == done_c)) begin
                errors++; $display("FAIL %s done cyc %0d got %0b exp %0b", name, k, done, (k == done_c));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy cyc %0d got %0b exp 1", name, k, busy);
            end
            if (bias_en === 1'b1) pulses++;
            start = restart && (k == 20 || k == done_c);
            hold  = h[k];
        end
        checks++;
        if (pulses != NUM) begin
            errors++; $display("FAIL %s pulse_count got %0d exp %0d", name, pulses, NUM);
        end
        $display("%s: done cycle %0d, %0d enable pulses", name, done_c, pulses);
        last_data = ed[done_c];
        hold = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < 128; a++) mem[a] = 8'(a + 1);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; hold = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, bias_en, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {rd_en, bias_en, busy, done});
        end
        checks++;
        if (rd_addr !== 7'(BASE)) begin
            errors++; $display("FAIL reset_addr got %0d exp %0d", rd_addr, BASE);
        end
        checks++;
        if (bias_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %0h exp 0", bias_data);
        end
        checks++;
        if (rd_addr1 !== 7'd5) begin
            errors++; $display("FAIL reset_addr1 got %0d exp 5", rd_addr1);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        last_data = 8'h00;
        $display("test_reset: outputs checked");
    endtask

    task automatic test_basic();
        fill_ramp();
        run_transfer("basic", 0, 0, 0, 1'b0);
    endtask

    task automatic test_hold_window();
        fill_ramp();
        run_transfer("hold_window", 1, 10, 14, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_ramp();
        run_transfer("restart_ignored", 0, 0, 0, 1'b1);
        run_transfer("second_transfer", 0, 0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        fill_ramp();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({rd_en, bias_en, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL async_rst_ctrl got %b exp 0000", {rd_en, bias_en, busy, done});
        end
        checks++;
        if (rd_addr !== 7'(BASE)) begin
            errors++; $display("FAIL async_rst_addr got %0d exp %0d", rd_addr, BASE);
        end
        checks++;
        if (bias_data !== 8'h00) begin
            errors++; $display("FAIL async_rst_data got %0h exp 0", bias_data);
        end
        $display("test_async_reset: outputs cleared mid-cycle");
        @(posedge clk); #1;
        rstn = 1'b1;
        last_data = 8'h00;
        run_transfer("after_reset", 0, 0, 0, 1'b0);
    endtask

    task automatic test_num1();
        for (int a = 0; a < 128; a++) mem1[a] = 8'($urandom);
        mem1[5] = 8'hA5;
        @(posedge clk); #1;
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            checks++;
            if (rd_en1 !== (k == 1)) begin
                errors++; $display("FAIL num1_rd_en cyc %0d got %0b exp %0b", k, rd_en1, (k == 1));
            end
            if (k == 1) begin
                checks++;
                if (rd_addr1 !== 7'd5) begin
                    errors++; $display("FAIL num1_addr got %0d exp 5", rd_addr1);
                end
            end
            checks++;
            if (bias_en1 !== (k == 3)) begin
                errors++; $display("FAIL num1_en cyc %0d got %0b exp %0b", k, bias_en1, (k == 3));
            end
            if (k >= 3) begin
                checks++;
                if (bias_data1 !== 8'hA5) begin
                    errors++; $display("FAIL num1_data cyc %0d got %0h exp a5", k, bias_data1);
                end
            end
            checks++;
            if (done1 !== (k == 4)) begin
                errors++; $display("FAIL num1_done cyc %0d got %0b exp %0b", k, done1, (k == 4));
            end
            checks++;
            if (busy1 !== (k <= 4)) begin
                errors++; $display("FAIL num1_busy cyc %0d got %0b exp %0b", k, busy1, (k <= 4));
            end
        end
        $display("test_num1: single-word transfer checked");
    endtask

    task automatic test_hold_at_start();
        fill_random();
        run_transfer("hold_at_start", 1, 0, $urandom_range(1, 6), 1'b0);
    endtask

    task automatic test_random_hold();
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_transfer("random_hold", 2, 0, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_window();
        test_back_to_back();
        test_async_reset();
        test_num1();
        test_hold_at_start();
        test_random_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
